// File: rtl/wb_regfile.sv
// MEM/WB write-back stage and 32-entry integer register file with same-cycle bypass.
// Optional debug read port enabled by defining REGFILE_DEBUG_EN.
module wb_regfile #(
   parameter int unsigned NBITS = 32,
   parameter int unsigned RBITS = 5
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [NBITS-1:0] WB_result,
   input  logic [NBITS-1:0] WB_data,
   input  logic [RBITS-1:0] WB_rd,
   input  logic             WB_regwrite,
   input  logic             WB_memtoreg,
   input  logic [RBITS-1:0] ID_rs,
   input  logic [RBITS-1:0] ID_rt,
   output logic [NBITS-1:0] o_rs_data,
   output logic [NBITS-1:0] o_rt_data,
   output logic [NBITS-1:0] o_wb_value,
`ifdef REGFILE_DEBUG_EN
   input  logic [RBITS-1:0] i_dbg_addr,
   output logic [NBITS-1:0] o_dbg_data,
`endif
   output logic             o_wb_active
);

   localparam int unsigned DEPTH = 2 ** RBITS;

   logic [NBITS-1:0] regs_q [DEPTH];
   logic [NBITS-1:0] wb_value;
   logic             wb_active;

   always_comb begin
      wb_value  = WB_memtoreg ? WB_data : WB_result;
      wb_active = WB_regwrite && (WB_rd != '0) && !i_rst;
   end

   // Reset takes priority over any write presented in the same cycle.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wb_active) begin
         regs_q[WB_rd] <= wb_value;
      end
   end

   // Write-before-read: a commit in this cycle is visible to the ID stage now.
   always_comb begin
      o_rs_data = regs_q[ID_rs];
      if (ID_rs == '0) begin
         o_rs_data = '0;
      end else if (wb_active && (ID_rs == WB_rd)) begin
         o_rs_data = wb_value;
      end

      o_rt_data = regs_q[ID_rt];
      if (ID_rt == '0) begin
         o_rt_data = '0;
      end else if (wb_active && (ID_rt == WB_rd)) begin
         o_rt_data = wb_value;
      end
   end

   assign o_wb_value  = wb_value;
   assign o_wb_active = wb_active;

`ifdef REGFILE_DEBUG_EN
   logic [NBITS-1:0] dbg_data_q;

   // Raw storage view, no bypass, so it reflects committed state only.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         dbg_data_q <= '0;
      end else begin
         dbg_data_q <= (i_dbg_addr == '0) ? '0 : regs_q[i_dbg_addr];
      end
   end

   assign o_dbg_data = dbg_data_q;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table, hand sequences and a random phase
// checked against a register-file model through an expected-result queue.
module tb_wb_regfile;

   logic        i_clk = 1'b0;
   logic        i_rst;
   logic [31:0] WB_result, WB_data;
   logic [4:0]  WB_rd, ID_rs, ID_rt;
   logic        WB_regwrite, WB_memtoreg;
   logic [31:0] o_rs_data, o_rt_data, o_wb_value;
   logic        o_wb_active;
`ifdef REGFILE_DEBUG_EN
   logic [4:0]  i_dbg_addr;
   logic [31:0] o_dbg_data;
`endif

   always #5 i_clk = ~i_clk;

   wb_regfile #(.NBITS(32), .RBITS(5)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .WB_result   (WB_result),
      .WB_data     (WB_data),
      .WB_rd       (WB_rd),
      .WB_regwrite (WB_regwrite),
      .WB_memtoreg (WB_memtoreg),
      .ID_rs       (ID_rs),
      .ID_rt       (ID_rt),
      .o_rs_data   (o_rs_data),
      .o_rt_data   (o_rt_data),
      .o_wb_value  (o_wb_value),
`ifdef REGFILE_DEBUG_EN
      .i_dbg_addr  (i_dbg_addr),
      .o_dbg_data  (o_dbg_data),
`endif
      .o_wb_active (o_wb_active)
   );

   typedef struct {
      logic        rst, we, m2r;
      logic [4:0]  rd, rs, rt;
      logic [31:0] res, dat;
      logic [31:0] e_rs, e_rt, e_wb;
      logic        e_act;
   } vec_t;

   typedef struct {
      logic [31:0] e_rs, e_rt, e_wb;
      logic        e_act;
   } exp_t;

   exp_t        sb[$];
   vec_t        vecs[13];
   logic [31:0] model[32];
   int          n_total = 0;
   int          n_pass  = 0;

   function automatic vec_t mk(input logic rst, input logic we, input logic m2r,
                               input logic [4:0] rd, input logic [31:0] res,
                               input logic [31:0] dat, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [31:0] e_rs,
                               input logic [31:0] e_rt, input logic [31:0] e_wb,
                               input logic e_act);
      vec_t v;
      v.rst = rst; v.we = we; v.m2r = m2r; v.rd = rd; v.res = res; v.dat = dat;
      v.rs = rs; v.rt = rt; v.e_rs = e_rs; v.e_rt = e_rt; v.e_wb = e_wb; v.e_act = e_act;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic drive(input vec_t v);
      exp_t e;
      i_rst = v.rst; WB_regwrite = v.we; WB_memtoreg = v.m2r; WB_rd = v.rd;
      WB_result = v.res; WB_data = v.dat; ID_rs = v.rs; ID_rt = v.rt;
      e.e_rs = v.e_rs; e.e_rt = v.e_rt; e.e_wb = v.e_wb; e.e_act = v.e_act;
      sb.push_back(e);
   endtask

   task automatic compare(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         n_total++;
         $display("FAIL %s: scoreboard empty, got 0 entries, expected 1", tag);
      end else begin
         e = sb.pop_front();
         check({tag, " rs_data"}, o_rs_data, e.e_rs);
         check({tag, " rt_data"}, o_rt_data, e.e_rt);
         check({tag, " wb_value"}, o_wb_value, e.e_wb);
         check({tag, " wb_active"}, {31'd0, o_wb_active}, {31'd0, e.e_act});
      end
   endtask

   // Drive just after the edge, compare just before the next one, then clock.
   task automatic apply(input vec_t v, input string tag);
      drive(v);
      #4;
      compare(tag);
      @(posedge i_clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_rst = 1'b0; WB_regwrite = 1'b0; WB_memtoreg = 1'b0; WB_rd = '0;
      WB_result = '0; WB_data = '0; ID_rs = '0; ID_rt = '0;
   endtask

   initial begin
      vec_t v;
      logic [31:0] wbv;
      logic        act;
`ifdef REGFILE_DEBUG_EN
      i_dbg_addr = '0;
`endif
      idle_inputs();
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;

      // Reset after a burst of random writes clears every entry.
      for (int i = 0; i < 10; i++) begin
         i_rst = 1'b0; WB_regwrite = 1'b1; WB_memtoreg = 1'($urandom_range(0, 1));
         WB_rd = 5'($urandom_range(1, 31)); WB_result = $urandom; WB_data = $urandom;
         @(posedge i_clk);
         #1;
      end
      idle_inputs();
      i_rst = 1'b1;
      repeat (2) @(posedge i_clk);
      #1;
      idle_inputs();
      for (int i = 0; i < 32; i++) begin
         v = mk(0, 0, 0, 0, 32'h0, 32'h0, 5'(i), 5'(31 - i), 32'h0, 32'h0, 32'h0, 0);
         drive(v);
         #1;
         compare($sformatf("reset_read[%0d]", i));
      end
      @(posedge i_clk);
      #1;

      //            rst we m2r rd  result        data          rs  rt  e_rs          e_rt          e_wb          act
      vecs[0]  = mk(0, 1, 0, 5,  32'hDEADBEEF, 32'h0,        5,  0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 1);
      vecs[1]  = mk(0, 0, 1, 5,  32'h0,        32'hFFFFFFFF, 5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFFFFF, 0);
      vecs[2]  = mk(0, 1, 1, 7,  32'hFFFFFFFF, 32'h12345678, 7,  5,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 1);
      vecs[3]  = mk(0, 0, 0, 7,  32'h0,        32'h0,        7,  0,  32'h12345678, 32'h0,        32'h0,        0);
      vecs[4]  = mk(0, 1, 0, 0,  32'hAAAA5555, 32'h0,        0,  0,  32'h0,        32'h0,        32'hAAAA5555, 0);
      vecs[5]  = mk(0, 0, 0, 0,  32'h0,        32'h0,        0,  0,  32'h0,        32'h0,        32'h0,        0);
      vecs[6]  = mk(0, 1, 0, 9,  32'h1,        32'h0,        9,  9,  32'h1,        32'h1,        32'h1,        1);
      vecs[7]  = mk(0, 1, 0, 9,  32'h2,        32'h0,        9,  9,  32'h2,        32'h2,        32'h2,        1);
      vecs[8]  = mk(0, 0, 0, 9,  32'h0,        32'h0,        9,  7,  32'h2,        32'h12345678, 32'h0,        0);
      vecs[9]  = mk(0, 1, 0, 31, 32'hCAFEF00D, 32'h0,        31, 30, 32'hCAFEF00D, 32'h0,        32'hCAFEF00D, 1);
      vecs[10] = mk(0, 0, 0, 31, 32'h0,        32'h0,        31, 1,  32'hCAFEF00D, 32'h0,        32'h0,        0);
      vecs[11] = mk(1, 1, 0, 3,  32'h55,       32'h0,        3,  5,  32'h0,        32'hDEADBEEF, 32'h55,       0);
      vecs[12] = mk(0, 0, 0, 3,  32'h0,        32'h0,        3,  5,  32'h0,        32'h0,        32'h0,        0);

      for (int i = 0; i < 13; i++) begin
`ifdef REGFILE_DEBUG_EN
         i_dbg_addr = 5'd3;
`endif
         apply(vecs[i], $sformatf("vec[%0d]", i));
`ifdef REGFILE_DEBUG_EN
         if (i == 11) begin
            #3;
            check("dbg_after_reset", o_dbg_data, 32'h0);
         end
`endif
      end

`ifdef REGFILE_DEBUG_EN
      // Debug port shows committed data one cycle after the address is set, no bypass.
      v = mk(0, 1, 0, 4, 32'h44, 32'h0, 4, 0, 32'h44, 32'h0, 32'h44, 1);
      i_dbg_addr = 5'd4;
      apply(v, "dbg_write");
      check("dbg_no_bypass", o_dbg_data, 32'h0);
      idle_inputs();
      @(posedge i_clk);
      #1;
      check("dbg_read", o_dbg_data, 32'h44);
`endif

      // Random phase against a register-file model; starts from a clean reset.
      idle_inputs();
      i_rst = 1'b1;
      @(posedge i_clk);
      #1;
      for (int i = 0; i < 32; i++) model[i] = '0;
      for (int i = 0; i < 80; i++) begin
         v.rst = ($urandom_range(0, 15) == 0);
         v.we  = 1'($urandom_range(0, 1));
         v.m2r = 1'($urandom_range(0, 1));
         v.rd  = 5'($urandom_range(0, 31));
         v.rs  = ($urandom_range(0, 1) == 1) ? v.rd : 5'($urandom_range(0, 31));
         v.rt  = ($urandom_range(0, 1) == 1) ? v.rd : 5'($urandom_range(0, 31));
         v.res = $urandom;
         v.dat = $urandom;
         wbv = v.m2r ? v.dat : v.res;
         act = v.we && (v.rd != 0) && !v.rst;
         v.e_wb = wbv;
         v.e_act = act;
         v.e_rs = (v.rs == 0) ? 32'h0 : (act && v.rs == v.rd) ? wbv : model[v.rs];
         v.e_rt = (v.rt == 0) ? 32'h0 : (act && v.rt == v.rd) ? wbv : model[v.rt];
         apply(v, $sformatf("rand[%0d]", i));
         if (v.rst) begin
            for (int k = 0; k < 32; k++) model[k] = '0;
         end else if (act) begin
            model[v.rd] = wbv;
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
